// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider: signed/unsigned, annul, divide-by-zero flag.
// Optional macro DIV_EARLY_OUT_EN skips the leading zeros of |dividend| (same result, less latency).
//
// state   | meaning
// IDLE    | waiting for start_i, result_o holds the last value
// DIVZERO | zero divisor seen, zero result goes out next edge
// ON      | one restoring step per cycle
// END     | ready_o high until start_i drops
module div_iter_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               div_zero_o,
   output logic               stallreq_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
   logic             q_neg_q, r_neg_q;
   logic [CNT_W-1:0] cnt_q, steps_q;

   logic             accept, dsr_zero, neg1, neg2;
   logic [WIDTH-1:0] abs1, abs2, dvd_init;
   logic [CNT_W-1:0] steps_init;
   logic             early_zero;
   logic [WIDTH:0]   shifted;
   logic             ge;
   logic [WIDTH-1:0] rem_step, quo_step, rem_fix, quo_fix;
   logic             last_step;

   assign accept   = (state_q == S_IDLE) && start_i && !annul_i;
   assign dsr_zero = (opdata2_i == '0);
   assign neg1     = signed_i & opdata1_i[WIDTH-1];
   assign neg2     = signed_i & opdata2_i[WIDTH-1];
   assign abs1     = neg1 ? -opdata1_i : opdata1_i;
   assign abs2     = neg2 ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
   function automatic logic [CNT_W-1:0] clz_f(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      logic             found;
      n     = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + CNT_W'(1);
         end
      end
      return n;
   endfunction

   logic [CNT_W-1:0] clz;
   assign clz        = clz_f(abs1);
   assign steps_init = CNT_W'(WIDTH) - clz;
   assign dvd_init   = abs1 << clz;
   assign early_zero = (abs1 == '0);
`else
   assign steps_init = CNT_W'(WIDTH);
   assign dvd_init   = abs1;
   assign early_zero = 1'b0;
`endif

   // dvd_q doubles as the quotient: dividend bits shift out the top, quotient bits in the bottom
   assign shifted   = {rem_q, dvd_q[WIDTH-1]};
   assign ge        = shifted >= {1'b0, dsr_q};
   assign rem_step  = ge ? (shifted[WIDTH-1:0] - dsr_q) : shifted[WIDTH-1:0];
   assign quo_step  = {dvd_q[WIDTH-2:0], ge};
   assign quo_fix   = q_neg_q ? -quo_step : quo_step;
   assign rem_fix   = r_neg_q ? -rem_step : rem_step;
   assign last_step = (cnt_q == steps_q - CNT_W'(1));

   assign ready_o    = (state_q == S_END);
   assign busy_o     = (state_q != S_IDLE);
   assign stallreq_o = start_i & ~ready_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (dsr_zero)        state_d = S_DIVZERO;
               else if (early_zero) state_d = S_END;
               else                 state_d = S_ON;
            end
         end
         S_DIVZERO: state_d = annul_i ? S_IDLE : S_END;
         S_ON: begin
            if (annul_i)        state_d = S_IDLE;
            else if (last_step) state_d = S_END;
         end
         S_END: begin
            if (annul_i || !start_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q      <= '0;
         dvd_q      <= '0;
         dsr_q      <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         cnt_q      <= '0;
         steps_q    <= '0;
         result_o   <= '0;
         div_zero_o <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept && !dsr_zero) begin
                  rem_q   <= '0;
                  dvd_q   <= dvd_init;
                  dsr_q   <= abs2;
                  q_neg_q <= neg1 ^ neg2;
                  r_neg_q <= neg1;
                  cnt_q   <= '0;
                  steps_q <= steps_init;
                  if (early_zero) begin
                     result_o   <= '0;
                     div_zero_o <= 1'b0;
                  end
               end
            end
            S_DIVZERO: begin
               if (!annul_i) begin
                  result_o   <= '0;
                  div_zero_o <= 1'b1;
               end
            end
            S_ON: begin
               if (!annul_i) begin
                  rem_q <= rem_step;
                  dvd_q <= quo_step;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_step) begin
                     result_o   <= {rem_fix, quo_fix};
                     div_zero_o <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: scoreboard of expected results, latency and stall checks.
module tb_div_iter_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic          annul_i = 1'b0;
   logic          signed_i = 1'b0;
   logic [W-1:0]  opdata1_i = '0;
   logic [W-1:0]  opdata2_i = '0;
   logic [2*W-1:0] result_o;
   logic          ready_o, busy_o, div_zero_o, stallreq_o;

   div_iter_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .signed_i(signed_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .result_o(result_o), .ready_o(ready_o),
      .busy_o(busy_o), .div_zero_o(div_zero_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] res;
      logic           dz;
      int             lat;
   } exp_t;

   exp_t           sb[$];
   int             n_cmp = 0;
   int             n_mis = 0;
   logic [2*W-1:0] last_res = '0;

   task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [W-1:0] absv(input bit sgn, input logic [W-1:0] v);
      return (sgn && v[W-1]) ? (~v + 1) : v;
   endfunction

   function automatic logic [2*W-1:0] model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] ua, ub, q, r;
      if (b == 0) return '0;
      ua = absv(sgn, a);
      ub = absv(sgn, b);
      q  = ua / ub;
      r  = ua % ub;
      if (sgn && (a[W-1] ^ b[W-1])) q = ~q + 1;
      if (sgn && a[W-1])            r = ~r + 1;
      return {r, q};
   endfunction

   function automatic int exp_lat(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
      logic [W-1:0] ua;
      int           msb;
`endif
      if (b == 0) return 2;
`ifdef DIV_EARLY_OUT_EN
      ua  = absv(sgn, a);
      msb = 0;
      for (int i = 0; i < W; i++) if (ua[i]) msb = i + 1;
      return msb + 1;
`else
      return W + 1;
`endif
   endfunction

   task automatic run_op(input string tag, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   cyc, stall;
      bit   got;
      e.res = model(sgn, a, b);
      e.dz  = (b == 0);
      e.lat = exp_lat(sgn, a, b);
      sb.push_back(e);
      @(negedge clk);
      signed_i  = sgn;
      opdata1_i = a;
      opdata2_i = b;
      start_i   = 1'b1;
      #1;
      stall = stallreq_o ? 1 : 0;
      cyc   = 0;
      got   = 1'b0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (ready_o) got = 1'b1;
         else if (stallreq_o) stall++;
      end
      e = sb.pop_front();
      chk({tag, " ready"}, 64'(got), 64'd1);
      if (got) begin
         chk({tag, " latency"}, 64'(cyc), 64'(e.lat));
         chk({tag, " result"}, result_o, e.res);
         chk({tag, " div_zero"}, 64'(div_zero_o), 64'(e.dz));
         chk({tag, " stall cycles"}, 64'(stall), 64'(e.lat));
         last_res = e.res;
         // operands after accept must not matter; start held in END must not restart
         opdata1_i = $urandom;
         opdata2_i = $urandom;
         signed_i  = ~sgn;
         @(negedge clk);
         chk({tag, " held ready"}, 64'(ready_o), 64'd1);
         chk({tag, " held result"}, result_o, e.res);
      end
      start_i = 1'b0;
      @(negedge clk);
      chk({tag, " busy after drop"}, 64'(busy_o), 64'd0);
      chk({tag, " ready after drop"}, 64'(ready_o), 64'd0);
      chk({tag, " result kept"}, result_o, last_res);
   endtask

   initial begin
      int rdy_seen;
      #1;
      chk("reset result", result_o, '0);
      chk("reset ready", 64'(ready_o), 64'd0);
      chk("reset busy", 64'(busy_o), 64'd0);
      chk("reset div_zero", 64'(div_zero_o), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("u100/7", 1'b0, 32'd100, 32'd7);
      chk("u100/7 const", result_o, {32'd2, 32'd14});
      run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      chk("s-7/2 const", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
      chk("s7/-2 const", result_o, {32'd1, 32'hFFFF_FFFD});
      run_op("div0", 1'b0, 32'h1234, 32'd0);
      chk("div0 flag kept", 64'(div_zero_o), 64'd1);
      run_op("u9/3", 1'b0, 32'd9, 32'd3);
      chk("u9/3 const", result_o, {32'd0, 32'd3});
      run_op("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("s ovf const", result_o, {32'd0, 32'h8000_0000});
      run_op("u ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("u ovf const", result_o, {32'h8000_0000, 32'd0});

      // annul in cycle 10
      @(negedge clk);
      signed_i = 1'b0; opdata1_i = 32'h7FFF_FFFF; opdata2_i = 32'd3; start_i = 1'b1;
      repeat (10) @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      chk("annul busy", 64'(busy_o), 64'd0);
      rdy_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready_o) rdy_seen++;
      end
      chk("annul no ready", 64'(rdy_seen), 64'd0);
      chk("annul result kept", result_o, last_res);

      // asynchronous reset mid-ON
      @(negedge clk);
      signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst result", result_o, '0);
      chk("arst ready", 64'(ready_o), 64'd0);
      chk("arst busy", 64'(busy_o), 64'd0);
      chk("arst div_zero", 64'(div_zero_o), 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_res = '0;

      run_op("u50/5", 1'b0, 32'd50, 32'd5);
      chk("u50/5 const", result_o, {32'd0, 32'd10});
      run_op("u5/1", 1'b0, 32'd5, 32'd1);
      run_op("u0/3", 1'b0, 32'd0, 32'd3);
      run_op("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (b == 0) b = 32'd1;
         run_op($sformatf("rnd%0d", i), 1'(i % 3 == 0), a, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Parametrised iterative radix-2 restoring divider for the EX stage; the successor to the fixed 32-bit divider.
- Accepts signed or unsigned operands via a start/ready handshake and produces {remainder, quotient} in HI/LO layout.
- Supports annul (flush) and flags divide-by-zero.
- Drives the EX stall request while a division is in flight.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1), step-counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start_i  input  1  request division; held high by EX until ready_o is seen.
- annul_i  input  1  abort the current or pending operation (pipeline flush).
- signed_i  input  1  1 = signed (two's complement), 0 = unsigned; sampled at accept.
- opdata1_i  input  WIDTH  dividend; sampled at accept.
- opdata2_i  input  WIDTH  divisor; sampled at accept.
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
- ready_o  output  1  result valid.
- busy_o  output  1  state != IDLE.
- div_zero_o  output  1  last result came from a zero divisor.
- stallreq_o  output  1  start_i & ~ready_o, combinational.

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - result_o = 0, ready_o = 0, div_zero_o = 0.
  - Counter and internal regs cleared.
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - Accept when start_i=1 and annul_i=0.
  - Divisor = 0: go to DIVZERO.
  - Otherwise latch |dividend|, |divisor|, quotient sign (sign1^sign2 when signed), remainder sign (sign1 when signed), steps = WIDTH, counter = 0; go to ON.
- DIVZERO: next edge goes to END with result_o = 0 and div_zero_o = 1.
- ON:
  - One restoring step per cycle: shift {rem, dvd} left 1; trial = rem - |divisor|; if non-negative, rem = trial and quotient bit = 1.
  - Counter increments.
  - On the edge that completes step `steps`: apply sign correction (negate quotient if its sign flag is set; negate remainder if its sign flag is set), register result_o, set div_zero_o = 0, go to END.
- END:
  - ready_o = 1; result_o held.
  - start_i = 0: go to IDLE, ready_o drops; result_o stays held until the next accept.
- Annul:
  - annul_i = 1 in ON, DIVZERO or END: next state IDLE, ready_o = 0, result_o unchanged.
  - annul_i has priority over accept and completion on the same edge.
- Latency, with accept at cycle 0:
  - Normal: ready_o high in cycle steps+1 (WIDTH+1 = 33 for WIDTH=32).
  - Divide-by-zero: ready_o high in cycle 2.
- stallreq_o is high from the accept cycle through the cycle before ready_o.
- Back-to-back operations need start_i low for at least one cycle (END→IDLE); a start held high in END does not restart.
- Signed overflow (most-negative / -1): quotient = most-negative (wraps), remainder = 0. No flag.
- Unsigned mode: operands taken as-is; sign flags forced to 0.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - At accept, compute clz of |dividend|; steps = WIDTH - clz.
  - Pre-shift the dividend left by clz.
  - |dividend| = 0 with nonzero divisor: steps = 0; go directly to END next edge with result 0 and div_zero_o = 0 (ready in cycle 1).
- Undefined: steps is always WIDTH and no clz logic is built.
- Results are identical in both builds; only latency differs.

Test Plan (WIDTH=32):
- Unsigned 100/7, start held → quotient 14, remainder 2; ready_o in cycle 33; stallreq_o high in cycles 0–32; busy_o low the cycle after start drops.
- Signed -7/2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 → quotient 0xFFFFFFFD, remainder 1.
- Divisor 0, dividend 0x1234 → result_o 0, div_zero_o 1, ready_o in cycle 2. A following 9/3 → quotient 3, div_zero_o 0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. The same operands unsigned → quotient 0, remainder 0x80000000.
- Annul:
  - annul_i pulsed in cycle 10 → IDLE next edge, ready_o never asserts, result_o unchanged.
  - rst pulsed asynchronously mid-ON → all outputs 0 immediately.
  - A subsequent 50/5 → quotient 10.
- With DIV_EARLY_OUT_EN: 5/1 → quotient 5, ready_o in cycle 4; 0/3 → ready_o in cycle 1, result 0.
- Without DIV_EARLY_OUT_EN: 5/1 → ready_o in cycle 33.
